mmu_mp: RTL and testbench
=========================

# mmu_mp

Multi-port successor to the single-requester memory unit. It arbitrates `NUM_PORTS` requesters (port 0 is the CPU, port 1 the PPU) onto one byte-wide block RAM of `2**ADDR_WIDTH` bytes using round-robin arbitration. Transfers are byte-serial, little-endian and 1..`MAX_BYTES` bytes long. Each port gets its own completion pulse and its own read-data register.

## Interface

Parameters:
- `NUM_PORTS`, 2: number of requester ports; 2..8.
- `ADDR_WIDTH`, 16: byte address width; memory depth is `2**ADDR_WIDTH`.
- `MAX_BYTES`, 2: maximum bytes per transfer; power of two, 2..8. `LEN_W = $clog2(MAX_BYTES)`.
- `ROM_TOP`, 16'h8000: first writable address; used only under the protect macro.

Ports (packed per port; port p occupies slice p):
- `clk` in 1: clock; all logic is on the rising edge.
- `reset_n` in 1: reset; one clock, synchronous, active-low.
- `req_op` in `NUM_PORTS` x `bus_op_t`: per-port `BUS_OP_IDLE`/`READ`/`WRITE`; level, held until done.
- `req_len` in `NUM_PORTS*LEN_W`: transfer length minus one (0 = 1 byte).
- `req_addr` in `NUM_PORTS*ADDR_WIDTH`: start byte address.
- `req_write_data` in `NUM_PORTS*8*MAX_BYTES`: write data; byte k goes to `addr+k`.
- `resp_done` out `NUM_PORTS`: one-cycle completion pulse per port.
- `resp_read_data` out `NUM_PORTS*8*MAX_BYTES`: per-port read result, zero-extended.
- `resp_err` out `NUM_PORTS`: protect-violation flag, valid with `resp_done`.

## Operation

- Memory is initialised to 0 at time zero. Reset does not clear memory.
- States: `S_IDLE` and `S_XFER`.
- **`S_IDLE`:**
  - Arbitrate among ports whose `req_op` is READ or WRITE.
  - Search order is `last+1`, `last+2`, … modulo `NUM_PORTS`.
  - The winner's op, len, addr and wdata are latched, `last` is set to the winner, and the block enters `S_XFER` with byte counter 0.
  - Any other op encoding counts as idle.
- **`S_XFER`:** one byte per cycle at `addr + k`, wrapping modulo `2**ADDR_WIDTH`.
  - Read: byte k is stored into lane k of the shift buffer.
  - Write: `mem[addr+k] <= wdata[8k+7:8k]`.
  - When `k == len`:
    - Assert `resp_done[port]` for one cycle.
    - On a read, load `resp_read_data[port]` with the buffer; lanes above `len` are 0.
    - Return to `S_IDLE`.
- `resp_read_data[p]` changes only when a read by port p completes. Writes and other ports' traffic leave it unchanged.
- A port whose `resp_done` is high in the current cycle is masked out of arbitration in that cycle. This lets the requester drop `req_op` without a duplicate grant.
- Requesters must keep inputs stable from assertion until done. Inputs are sampled only at grant.
- **Reset:**
  - `resp_done`, `resp_err` and `resp_read_data` go to 0.
  - State goes to `S_IDLE`.
  - `last` goes to `NUM_PORTS-1`, so port 0 has first priority.
  - A transfer in progress is aborted with no done pulse. Bytes already written remain in memory.

## Timing

- Request sampled in `S_IDLE` at edge E0. Byte k is accessed at edge E(k+1). `resp_done` is high in the cycle after edge E(len+1).
- Latency by size: 1 byte = 2 edges; 2 bytes = 3 edges; `MAX_BYTES` = `MAX_BYTES+1` edges.
- The block is back in `S_IDLE` in the same cycle that `resp_done` is high. A different port can be granted at that edge, giving back-to-back throughput of len+2 cycles per transfer.
- A read of a byte written by an earlier transfer returns the new value. There is no intra-transfer hazard, because each byte is accessed once.
- With two simultaneous requests, the port not granted waits at least len+2 cycles. With all ports continuously requesting, no port waits more than `NUM_PORTS-1` transfers.

## Configuration

- **`MMU_MP_ROM_PROTECT_EN` defined:**
  - Write bytes with address < `ROM_TOP` are suppressed individually. Other bytes in the same transfer are still written.
  - `resp_err[port]` pulses with `resp_done` if any byte was suppressed.
  - Reads are unaffected.
- **Not defined:** all writes are performed; `resp_err` is tied to 0.

## Test plan

- **Byte read/write, port 0:**
  - Write len 0, addr 16'hC000, data 8'hA5 → done 2 edges after sample.
  - Read len 0 from the same address → `resp_read_data[0]` = 16'h00A5.
- **Word wrap:**
  - Write len 1, addr 16'hFFFF, data 16'h1234 → mem[FFFF]=34, mem[0000]=12.
  - Word read at FFFF → 16'h1234, done 3 edges after sample.
- **Round-robin:**
  - Ports 0 and 1 request simultaneously from reset → port 0 is served first, then port 1.
  - Port 0 then holds requesting → it is served only after port 1's done.
  - Port 1's `resp_read_data` stays unchanged during port 0's transfers.
- **Done masking:** port 0 holds `req_op` one extra cycle after `resp_done` → exactly one transfer occurs, with no second done pulse.
- **Reset mid-write:**
  - Word write 16'hBEEF at 16'hC010; drop `reset_n` after the first byte edge.
  - Expect mem[C010]=EF, mem[C011] unchanged, no `resp_done`, all outputs 0.
- **Protect (macro on):**
  - Word write 16'hCAFE at 16'h7FFF → mem[7FFF] unchanged, mem[8000]=CA.
  - `resp_err` and `resp_done` are high in the same cycle.

Source files
------------

// File: rtl/mmu_mp.sv
// mmu_mp: round-robin arbiter of NUM_PORTS requesters onto one byte-serial, byte-wide RAM.
// Define MMU_MP_ROM_PROTECT_EN to suppress writes below ROM_TOP and flag them on resp_err.
package mmu_mp_pkg;
    typedef enum logic [1:0] {
        BUS_OP_IDLE  = 2'b00,
        BUS_OP_READ  = 2'b01,
        BUS_OP_WRITE = 2'b10
    } bus_op_t;
endpackage

module mmu_mp
    import mmu_mp_pkg::*;
#(
    parameter int unsigned           NUM_PORTS  = 2,
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter int unsigned           MAX_BYTES  = 2,
    parameter logic [ADDR_WIDTH-1:0] ROM_TOP    = 16'h8000,
    localparam int unsigned          LEN_W      = $clog2(MAX_BYTES)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  bus_op_t [NUM_PORTS-1:0]          req_op,
    input  logic [NUM_PORTS*LEN_W-1:0]       req_len,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*8*MAX_BYTES-1:0] req_write_data,
    output logic [NUM_PORTS-1:0]             resp_done,
    output logic [NUM_PORTS*8*MAX_BYTES-1:0] resp_read_data,
    output logic [NUM_PORTS-1:0]             resp_err
);

    localparam int unsigned DW = 8 * MAX_BYTES;
    localparam int unsigned PW = $clog2(NUM_PORTS);

    typedef enum logic {
        S_IDLE,
        S_XFER
    } state_t;

    state_t                state_q;
    logic [PW-1:0]         last_q;
    logic [PW-1:0]         port_q;
    logic                  is_write_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [DW-1:0]         wdata_q;
    logic [DW-1:0]         rbuf_q;
    logic                  err_acc_q;

    logic [7:0] mem [2**ADDR_WIDTH] = '{default: 8'h00};

    // A port completing this cycle is masked so a held req_op is not granted twice.
    logic [NUM_PORTS-1:0] req_active;
    always_comb begin
        req_active = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            req_active[p] = (req_op[p] == BUS_OP_READ || req_op[p] == BUS_OP_WRITE)
                            && !resp_done[p];
        end
    end

    logic          grant_valid;
    logic [PW-1:0] grant_port;
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_port  = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            idx = (int'(last_q) + i) % NUM_PORTS;
            if (!grant_valid && req_active[idx]) begin
                grant_valid = 1'b1;
                grant_port  = PW'(idx);
            end
        end
    end

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [7:0]            cur_rbyte;
    logic [7:0]            cur_wbyte;
    logic                  last_byte;
    logic                  suppress;
    logic                  err_now;
    logic                  mem_we;
    logic [DW-1:0]         rbuf_next;

    assign cur_addr  = base_q + ADDR_WIDTH'(cnt_q);
    assign cur_rbyte = mem[cur_addr];
    assign cur_wbyte = wdata_q[{cnt_q, 3'b000} +: 8];
    assign last_byte = (cnt_q == len_q);

`ifdef MMU_MP_ROM_PROTECT_EN
    assign suppress = (cur_addr < ROM_TOP);
`else
    logic unused_rom_top;
    assign unused_rom_top = ^ROM_TOP;
    assign suppress       = 1'b0;
`endif

    assign err_now = is_write_q & suppress;
    // Gated by reset so an aborted transfer stops writing on the reset edge.
    assign mem_we  = reset_n && (state_q == S_XFER) && is_write_q && !suppress;

    always_comb begin
        rbuf_next                      = rbuf_q;
        rbuf_next[{cnt_q, 3'b000} +: 8] = cur_rbyte;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_addr] <= cur_wbyte;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            last_q         <= PW'(NUM_PORTS - 1);
            port_q         <= '0;
            is_write_q     <= 1'b0;
            len_q          <= '0;
            cnt_q          <= '0;
            base_q         <= '0;
            wdata_q        <= '0;
            rbuf_q         <= '0;
            err_acc_q      <= 1'b0;
            resp_done      <= '0;
            resp_err       <= '0;
            resp_read_data <= '0;
        end else begin
            resp_done <= '0;
            resp_err  <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (grant_valid) begin
                        port_q     <= grant_port;
                        last_q     <= grant_port;
                        is_write_q <= (req_op[grant_port] == BUS_OP_WRITE);
                        len_q      <= req_len[grant_port*LEN_W +: LEN_W];
                        base_q     <= req_addr[grant_port*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_q    <= req_write_data[grant_port*DW +: DW];
                        rbuf_q     <= '0;
                        cnt_q      <= '0;
                        err_acc_q  <= 1'b0;
                        state_q    <= S_XFER;
                    end
                end
                S_XFER: begin
                    rbuf_q    <= rbuf_next;
                    err_acc_q <= err_acc_q | err_now;
                    cnt_q     <= cnt_q + 1'b1;
                    if (last_byte) begin
                        resp_done[port_q] <= 1'b1;
                        resp_err[port_q]  <= err_acc_q | err_now;
                        if (!is_write_q) begin
                            resp_read_data[port_q*DW +: DW] <= rbuf_next;
                        end
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_mp.sv
// Self-checking bench for mmu_mp: scoreboard of completions plus per-scenario inline checks.
module tb_mmu_mp;
    import mmu_mp_pkg::*;

    localparam int NP = 2;
    localparam int AW = 16;
    localparam int MB = 2;
    localparam int LW = $clog2(MB);
    localparam int DW = 8 * MB;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    bus_op_t [NP-1:0] req_op;
    logic [NP*LW-1:0] req_len;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_write_data;
    logic [NP-1:0]    resp_done;
    logic [NP*DW-1:0] resp_read_data;
    logic [NP-1:0]    resp_err;

    typedef struct {
        int            port;
        bit            chk_data;
        logic [DW-1:0] data;
        bit            err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mmu_mp #(
        .NUM_PORTS (NP),
        .ADDR_WIDTH(AW),
        .MAX_BYTES (MB),
        .ROM_TOP   (16'h8000)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_op        (req_op),
        .req_len       (req_len),
        .req_addr      (req_addr),
        .req_write_data(req_write_data),
        .resp_done     (resp_done),
        .resp_read_data(resp_read_data),
        .resp_err      (resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Completion monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int p = 0; p < NP; p++) begin
            if (reset_n && resp_done[p]) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: port %0d pulsed resp_done, required none", p);
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (p !== e.port) begin
                        n_bad++;
                        $display("FAIL done_order: got port %0d, required port %0d", p, e.port);
                    end
                    n_cmp++;
                    if (resp_err[p] !== e.err) begin
                        n_bad++;
                        $display("FAIL resp_err: port %0d got %b, required %b", p, resp_err[p],
                                 e.err);
                    end
                    if (e.chk_data) begin
                        n_cmp++;
                        if (resp_read_data[p*DW +: DW] !== e.data) begin
                            n_bad++;
                            $display("FAIL read_data: port %0d got %h, required %h", p,
                                     resp_read_data[p*DW +: DW], e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic set_req(input int p, input bus_op_t op, input int len,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req_op[p]               = op;
        req_len[p*LW +: LW]     = LW'(len);
        req_addr[p*AW +: AW]    = addr;
        req_write_data[p*DW +: DW] = wd;
    endtask

    task automatic push_exp(input int p, input bit chk, input logic [DW-1:0] d, input bit err);
        exp_t e;
        e.port     = p;
        e.chk_data = chk;
        e.data     = d;
        e.err      = err;
        sb.push_back(e);
    endtask

    // Single-port transfer; cyc is edges from request to observed done, -1 on timeout.
    task automatic xfer(input int p, input bus_op_t op, input int len, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output int cyc);
        cyc = -1;
        set_req(p, op, len, addr, wd);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (resp_done[p]) begin
                cyc = i;
                break;
            end
        end
        req_op[p] = BUS_OP_IDLE;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int p = 0; p < NP; p++) set_req(p, BUS_OP_IDLE, 0, '0, '0);
        apply_reset();
        n_cmp++;
        if (resp_done !== '0) begin
            n_bad++;
            $display("FAIL reset_done: got %b, required 0", resp_done);
        end
        n_cmp++;
        if (resp_err !== '0) begin
            n_bad++;
            $display("FAIL reset_err: got %b, required 0", resp_err);
        end
        n_cmp++;
        if (resp_read_data !== '0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h, required 0", resp_read_data);
        end
    endtask

    task automatic test_byte_rw();
        int cyc;
        push_exp(0, 1'b0, '0, 1'b0);
        xfer(0, BUS_OP_WRITE, 0, 16'hC000, 16'h00A5, cyc);
        n_cmp++;
        if (cyc !== 2) begin
            n_bad++;
            $display("FAIL byte_write_latency: got %0d, required 2", cyc);
        end
        push_exp(0, 1'b1, 16'h00A5, 1'b0);
        xfer(0, BUS_OP_READ, 0, 16'hC000, '0, cyc);
        n_cmp++;
        if (cyc !== 2) begin
            n_bad++;
            $display("FAIL byte_read_latency: got %0d, required 2", cyc);
        end
    endtask

    task automatic test_word_wrap();
        int cyc;
        push_exp(0, 1'b0, '0, 1'b0);
        xfer(0, BUS_OP_WRITE, 1, 16'hFFFF, 16'h1234, cyc);
        n_cmp++;
        if (cyc !== 3) begin
            n_bad++;
            $display("FAIL word_write_latency: got %0d, required 3", cyc);
        end
        push_exp(0, 1'b1, 16'h1234, 1'b0);
        xfer(0, BUS_OP_READ, 1, 16'hFFFF, '0, cyc);
        n_cmp++;
        if (cyc !== 3) begin
            n_bad++;
            $display("FAIL word_read_latency: got %0d, required 3", cyc);
        end
        // Each byte separately: upper lane must read back as zero.
        push_exp(0, 1'b1, 16'h0012, 1'b0);
        xfer(0, BUS_OP_READ, 0, 16'h0000, '0, cyc);
        push_exp(0, 1'b1, 16'h0034, 1'b0);
        xfer(0, BUS_OP_READ, 0, 16'hFFFF, '0, cyc);
    endtask

    task automatic test_round_robin();
        int cyc = 0;
        int n0 = 0;
        int t0a = -1;
        int t0b = -1;
        int t1 = -1;
        apply_reset();
        push_exp(0, 1'b1, 16'h00A5, 1'b0);
        push_exp(1, 1'b1, 16'h1234, 1'b0);
        push_exp(0, 1'b0, '0, 1'b0);
        set_req(0, BUS_OP_READ, 0, 16'hC000, '0);
        set_req(1, BUS_OP_READ, 1, 16'hFFFF, '0);
        while (cyc < 30 && t0b < 0) begin
            @(negedge clk);
            cyc++;
            if (resp_done[0]) begin
                n0++;
                if (n0 == 1) begin
                    t0a = cyc;
                    set_req(0, BUS_OP_WRITE, 0, 16'hC002, 16'h0077);
                end else begin
                    t0b = cyc;
                    req_op[0] = BUS_OP_IDLE;
                end
            end
            if (resp_done[1]) begin
                t1 = cyc;
                req_op[1] = BUS_OP_IDLE;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (t0a !== 2) begin
            n_bad++;
            $display("FAIL rr_port0_first: done at %0d, required 2", t0a);
        end
        n_cmp++;
        if (t1 !== 5) begin
            n_bad++;
            $display("FAIL rr_port1_second: done at %0d, required 5", t1);
        end
        n_cmp++;
        if (t0b !== 7) begin
            n_bad++;
            $display("FAIL rr_port0_again: done at %0d, required 7", t0b);
        end
        n_cmp++;
        if (resp_read_data[1*DW +: DW] !== 16'h1234) begin
            n_bad++;
            $display("FAIL rr_port1_hold: got %h, required 1234", resp_read_data[1*DW +: DW]);
        end
        n_cmp++;
        if (resp_read_data[0 +: DW] !== 16'h00A5) begin
            n_bad++;
            $display("FAIL rr_port0_hold: got %h, required 00a5", resp_read_data[0 +: DW]);
        end
    endtask

    task automatic test_done_mask();
        int dones = 0;
        int cyc;
        push_exp(0, 1'b0, '0, 1'b0);
        set_req(0, BUS_OP_WRITE, 0, 16'hC004, 16'h005A);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (resp_done[0]) dones++;
            if (i == 3) req_op[0] = BUS_OP_IDLE;
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++;
            $display("FAIL done_mask: got %0d done pulses, required 1", dones);
        end
        push_exp(0, 1'b1, 16'h005A, 1'b0);
        xfer(0, BUS_OP_READ, 0, 16'hC004, '0, cyc);
        n_cmp++;
        if (cyc !== 2) begin
            n_bad++;
            $display("FAIL done_mask_read_latency: got %0d, required 2", cyc);
        end
    endtask

    task automatic test_reset_mid_write();
        int cyc;
        set_req(0, BUS_OP_WRITE, 1, 16'hC010, 16'hBEEF);
        @(negedge clk);
        @(negedge clk);
        reset_n   = 1'b0;
        req_op[0] = BUS_OP_IDLE;
        @(negedge clk);
        n_cmp++;
        if (resp_done !== '0 || resp_err !== '0 || resp_read_data !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got done %b err %b rdata %h, required all 0",
                     resp_done, resp_err, resp_read_data);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (resp_done !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_no_done: got %b, required 0", resp_done);
        end
        push_exp(0, 1'b1, 16'h00EF, 1'b0);
        xfer(0, BUS_OP_READ, 1, 16'hC010, '0, cyc);
        n_cmp++;
        if (cyc !== 3) begin
            n_bad++;
            $display("FAIL mid_reset_read_latency: got %0d, required 3", cyc);
        end
    endtask

    task automatic test_protect();
        int cyc;
`ifdef MMU_MP_ROM_PROTECT_EN
        push_exp(1, 1'b0, '0, 1'b1);
`else
        push_exp(1, 1'b0, '0, 1'b0);
`endif
        xfer(1, BUS_OP_WRITE, 1, 16'h7FFF, 16'hCAFE, cyc);
        n_cmp++;
        if (cyc !== 3) begin
            n_bad++;
            $display("FAIL protect_write_latency: got %0d, required 3", cyc);
        end
`ifdef MMU_MP_ROM_PROTECT_EN
        push_exp(1, 1'b1, 16'hCA00, 1'b0);
`else
        push_exp(1, 1'b1, 16'hCAFE, 1'b0);
`endif
        xfer(1, BUS_OP_READ, 1, 16'h7FFF, '0, cyc);
    endtask

    initial begin
        test_reset();
        test_byte_rw();
        test_word_wrap();
        test_round_robin();
        test_done_mask();
        test_reset_mid_write();
        test_protect();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL missing_done: %0d completions outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
